// File: rtl/terminal_char_sender.sv
// Sender side of the terminal character interface: buffers host characters in a
// small FIFO and offers them one at a time to the terminal over the DA/RDA handshake.
module terminal_char_sender #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned UPCASE  = 1
) (
  input  logic       clk,
  input  logic       mr_n,
  input  logic       wr_en,
  input  logic [6:0] wr_data,
  output logic       full,
  output logic       overflow,
  output logic       timeout,
  input  logic       clr_err,
  input  logic       rda,
  output logic       da,
  output logic [6:0] char_out,
  output logic       busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = 16;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    WAIT_RDY
  } state_t;

  logic [6:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic          da_q;
  logic [6:0]    char_q;
  logic          ovf_q;
  logic          tmo_q;

  logic          full_w;
  logic          push;
  logic          pop;
  logic          ovf_set;
  logic          tmo_set;
  logic [6:0]    wr_conv;

  always_comb begin
    wr_conv = wr_data;
    if ((UPCASE != 0) && (wr_data >= 7'h61) && (wr_data <= 7'h7A)) begin
      wr_conv = wr_data - 7'h20;
    end
  end

  // Full is taken from the registered count, so a write while full is dropped
  // even if a pop happens on the same edge.
  always_comb begin
    full_w  = (count_q == CW'(DEPTH));
    push    = wr_en && !full_w;
    pop     = (state_q == IDLE) && (count_q != '0) && rda;
    ovf_set = wr_en && full_w;
    tmo_set = (state_q == PRESENT) && rda && (timer_q == TW'(TIMEOUT - 1));
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_conv;
    end
  end

  always_ff @(posedge clk or negedge mr_n) begin
    if (!mr_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (clr_err) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge mr_n) begin
    if (!mr_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      da_q    <= 1'b0;
      char_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            char_q  <= mem_q[rd_ptr_q];
            timer_q <= '0;
            da_q    <= 1'b1;
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          if (!rda) begin
            da_q    <= 1'b0;
            state_q <= WAIT_RDY;
          end else if (tmo_set) begin
            da_q    <= 1'b0;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        WAIT_RDY: begin
          if (rda) begin
            state_q <= IDLE;
          end
        end
        default: begin
          da_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
      if (tmo_set) begin
        tmo_q <= 1'b1;
      end else if (clr_err) begin
        tmo_q <= 1'b0;
      end
    end
  end

  assign full     = full_w;
  assign overflow = ovf_q;
  assign timeout  = tmo_q;
  assign da       = da_q;
  assign char_out = char_q;
  assign busy     = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_terminal_char_sender.sv
// Bench for terminal_char_sender: constant vector table, hand-written corner
// sequences and random traffic, all checked against a queue-based reference.
module tb_terminal_char_sender;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       mr_n;
  logic       wr_en;
  logic [6:0] wr_data;
  logic       full;
  logic       overflow;
  logic       timeout;
  logic       clr_err;
  logic       rda;
  logic       da;
  logic [6:0] char_out;
  logic       busy;

  always #5 clk = ~clk;

  terminal_char_sender #(
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT),
    .UPCASE (1)
  ) dut (
    .clk     (clk),
    .mr_n    (mr_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .overflow(overflow),
    .timeout (timeout),
    .clr_err (clr_err),
    .rda     (rda),
    .da      (da),
    .char_out(char_out),
    .busy    (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference: a queue of stored characters plus "showing"/"waiting" flags and
  // the number of cycles the current character has been offered.
  logic [6:0] mq[$];
  bit         m_show;
  bit         m_wait;
  int         m_age;
  logic [6:0] m_char;
  bit         m_ovf;
  bit         m_tmo;

  logic [6:0] delivered[$];
  bit         prev_da;

  typedef struct {
    bit         wr;
    logic [6:0] d;
    bit         r;
    bit         c;
    bit         e_da;
    logic [6:0] e_ch;
    bit         e_full;
    bit         e_busy;
  } vec_t;

  vec_t tbl[17];

  function automatic logic [6:0] upc(input logic [6:0] d);
    return ((d >= 7'h61) && (d <= 7'h7A)) ? d - 7'h20 : d;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_show = 1'b0;
    m_wait = 1'b0;
    m_age  = 0;
    m_char = 7'h00;
    m_ovf  = 1'b0;
    m_tmo  = 1'b0;
  endfunction

  function automatic void model_edge(input bit wr, input logic [6:0] d, input bit r, input bit c);
    bit         was_full;
    bit         take;
    bit         expired;
    logic [6:0] head;
    was_full = (mq.size() == DEPTH);
    take     = !m_show && !m_wait && (mq.size() != 0) && r;
    expired  = 1'b0;
    head     = 7'h00;
    if (take) head = mq.pop_front();
    if (wr && !was_full) mq.push_back(upc(d));
    m_ovf = (wr && was_full) ? 1'b1 : (c ? 1'b0 : m_ovf);
    if (take) begin
      m_char = head;
      m_show = 1'b1;
      m_age  = 1;
    end else if (m_show) begin
      if (!r) begin
        m_show = 1'b0;
        m_wait = 1'b1;
      end else if (m_age == TIMEOUT) begin
        m_show  = 1'b0;
        expired = 1'b1;
      end else begin
        m_age++;
      end
    end else if (m_wait && r) begin
      m_wait = 1'b0;
    end
    m_tmo = expired ? 1'b1 : (c ? 1'b0 : m_tmo);
  endfunction

  task automatic check_model(input string tag);
    logic [11:0] got;
    logic [11:0] exp;
    got = {da, char_out, full, overflow, timeout, busy};
    exp = {m_show, m_char, (mq.size() == DEPTH), m_ovf, m_tmo,
           ((mq.size() != 0) || m_show || m_wait)};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d da/char/full/ovf/tmo/busy got=%b/%h/%b/%b/%b/%b expected=%b/%h/%b/%b/%b/%b",
               tag, cyc, got[11], got[10:4], got[3], got[2], got[1], got[0],
               exp[11], exp[10:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_const(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit wr, input logic [6:0] d, input bit r, input bit c, input string tag);
    wr_en   = wr;
    wr_data = d;
    rda     = r;
    clr_err = c;
    @(posedge clk);
    model_edge(wr, d, r, c);
    cyc++;
    @(negedge clk);
    check_model(tag);
    if (da && !prev_da) delivered.push_back(char_out);
    prev_da = da;
  endtask

  task automatic apply_reset();
    wr_en   = 1'b0;
    wr_data = 7'h00;
    rda     = 1'b0;
    clr_err = 1'b0;
    mr_n    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_const("reset_state", 32'({da, char_out, full, overflow, timeout, busy}), 32'd0);
    model_reset();
    mr_n    = 1'b1;
    prev_da = 1'b0;
    delivered.delete();
  endtask

  // Terminal that accepts each character the cycle after it appears.
  task automatic drain(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (busy && (n < max_cyc)) begin
      step(1'b0, 7'h00, !da, 1'b0, tag);
      n++;
    end
    check_const({tag, "_drained"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 7'h41, 1'b1, 1'b0, 1'b0, 7'h00, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 7'h41, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 7'h41, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 7'h41, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 7'h41, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 7'h41, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 7'h41, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 7'h61, 1'b1, 1'b0, 1'b0, 7'h41, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 7'h7A, 1'b1, 1'b0, 1'b1, 7'h41, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 7'h7B, 1'b0, 1'b0, 1'b0, 7'h41, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 7'h41, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 7'h5A, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 7'h5A, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 7'h5A, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 7'h7B, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 7'h7B, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 7'h7B, 1'b0, 1'b0};

    wr_en   = 1'b0;
    wr_data = 7'h00;
    rda     = 1'b0;
    clr_err = 1'b0;
    mr_n    = 1'b0;
    prev_da = 1'b0;
    model_reset();
    @(negedge clk);
    apply_reset();

    // Single handshake followed by upper-casing sequence.
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].wr, tbl[i].d, tbl[i].r, tbl[i].c, "tbl_model");
      check_const($sformatf("tbl_vec%0d", i), 32'({da, char_out, full, busy}),
                  32'({tbl[i].e_da, tbl[i].e_ch, tbl[i].e_full, tbl[i].e_busy}));
    end

    // FIFO fill, overflow and pointer wrap.
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 7'(8'h30 + i), 1'b0, 1'b0, "t3_fill");
      if (i == 6) check_const("t3_not_full_7", 32'(full), 32'd0);
      if (i == 7) check_const("t3_full_8", 32'({full, overflow}), 32'b10);
      if (i == 8) check_const("t3_ovf_9", 32'(overflow), 32'd1);
    end
    delivered.delete();
    drain(100, "t3_drain1");
    check_const("t3_count1", 32'(delivered.size()), 32'd8);
    for (int i = 0; (i < delivered.size()) && (i < 8); i++)
      check_const($sformatf("t3_order1_%0d", i), 32'(delivered[i]), 32'(8'h30 + i));
    for (int i = 0; i < 8; i++) step(1'b1, 7'(8'h61 + i), 1'b0, 1'b0, "t3_burst2");
    check_const("t3_full_again", 32'(full), 32'd1);
    delivered.delete();
    drain(100, "t3_drain2");
    check_const("t3_count2", 32'(delivered.size()), 32'd8);
    for (int i = 0; (i < delivered.size()) && (i < 8); i++)
      check_const($sformatf("t3_order2_%0d", i), 32'(delivered[i]), 32'(8'h41 + i));
    step(1'b0, 7'h00, 1'b1, 1'b1, "t3_clr");
    check_const("t3_ovf_cleared", 32'(overflow), 32'd0);

    // Timeout: terminal never drops rda.
    apply_reset();
    begin
      int highs;
      step(1'b1, 7'h78, 1'b1, 1'b0, "t4_w1");
      step(1'b1, 7'h79, 1'b1, 1'b0, "t4_w2");
      highs = da ? 1 : 0;
      for (int k = 0; k < 40; k++) begin
        if (!da) break;
        step(1'b0, 7'h00, 1'b1, 1'b0, "t4_hold");
        if (da) highs++;
      end
      check_const("t4_da_cycles", 32'(highs), 32'(TIMEOUT));
      check_const("t4_tmo_set", 32'({da, timeout}), 32'b01);
      step(1'b0, 7'h00, 1'b1, 1'b0, "t4_next");
      check_const("t4_next_char", 32'({da, char_out}), 32'({1'b1, 7'h59}));
      step(1'b0, 7'h00, 1'b0, 1'b0, "t4_accept");
      step(1'b0, 7'h00, 1'b1, 1'b0, "t4_idle");
      step(1'b0, 7'h00, 1'b1, 1'b1, "t4_clr");
      check_const("t4_tmo_cleared", 32'(timeout), 32'd0);
    end

    // Push and pop on the same edge with three entries stored.
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 7'(8'h50 + i), 1'b0, 1'b0, "t5_fill");
    delivered.delete();
    step(1'b1, 7'h53, 1'b1, 1'b0, "t5_pushpop");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 7'(8'h54 + i), 1'b0, 1'b0, "t5_top");
      if (i == 3) check_const("t5_not_full_7", 32'(full), 32'd0);
      if (i == 4) check_const("t5_full_8", 32'(full), 32'd1);
    end
    drain(100, "t5_drain");
    check_const("t5_count", 32'(delivered.size()), 32'd9);
    for (int i = 0; (i < delivered.size()) && (i < 9); i++)
      check_const($sformatf("t5_order_%0d", i), 32'(delivered[i]), 32'(8'h50 + i));

    // Asynchronous reset in the middle of a presentation.
    apply_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 7'(8'h30 + i), 1'b0, 1'b0, "t6_fill");
    step(1'b0, 7'h00, 1'b1, 1'b0, "t6_present");
    check_const("t6_pre", 32'({da, overflow, busy}), 32'b111);
    #2 mr_n = 1'b0;
    #1 check_const("t6_async", 32'({da, char_out, full, overflow, timeout, busy}), 32'd0);
    @(negedge clk);
    model_reset();
    mr_n    = 1'b1;
    prev_da = 1'b0;
    begin
      int rises;
      delivered.delete();
      for (int k = 0; k < 6; k++) step(1'b0, 7'h00, 1'b1, 1'b0, "t6_quiet");
      rises = delivered.size();
      check_const("t6_no_da", 32'(rises), 32'd0);
    end

    // Random traffic against the reference.
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 9) < 4), 7'($urandom), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 19) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
